snn_result_reporter: RTL

SNN_RESULT_REPORTER -- requirements
Module: snn_result_reporter

---
 rtl/snn_report_pkg.sv | 35 +++
 rtl/snn_result_reporter_fifo.sv | 47 ++++
 rtl/snn_result_reporter.sv | 102 ++++++++++
 3 files changed

// File: rtl/snn_report_pkg.sv
// Shared definitions for the SNN result reporter: FSM states, ASCII frame bytes
// and the frame byte selector.
package snn_report_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    localparam logic [7:0] CH_D    = 8'h44;
    localparam logic [7:0] CH_EQ   = 8'h3D;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_QM   = 8'h3F;
    localparam logic [7:0] CH_ZERO = 8'h30;

    localparam int         MSG_LEN  = 5;
    localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

    // Byte idx of the frame "D=<char>\r\n"; non-decimal results print as '?'.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [3:0] d);
        // NOTE: every path assigns the result, so no storage is implied in comb logic.
        frame_byte = CH_LF;
        case (idx)
            3'd0:    frame_byte = CH_D;
            3'd1:    frame_byte = CH_EQ;
            3'd2:    frame_byte = (d < 4'd10) ? (CH_ZERO + {4'h0, d}) : CH_QM;
            3'd3:    frame_byte = CH_CR;
            default: frame_byte = CH_LF;
        endcase
    endfunction

endpackage

// File: rtl/snn_result_reporter_fifo.sv
// Small result FIFO for the reporter: 4-bit entries, extra pointer bit tells
// full from empty when the wrapped pointers coincide.
module result_fifo
    import snn_report_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [3:0] push_data,
    input  logic       pop,
    output logic [3:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [3:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/snn_result_reporter.sv
// Buffers classifier results and sends each one to a UART as "D=<char>\r\n",
// with a status LED byte and a sticky drop flag.
module snn_result_reporter
    import snn_report_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic [3:0] digit,
    input  logic       tx_rdy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [7:0] led,
    output logic       overflow
);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] msg;
    logic [2:0] frame_cnt;
    logic [1:0] wait_cnt;

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [3:0] fifo_dout;
    logic       ovf_next;

    assign fifo_pop = (state == IDLE) && !fifo_empty;
    // A drop is decided on the pre-pop fullness, so a same-cycle pop never rescues it.
    assign ovf_next = overflow || (done && fifo_full);

    result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (done),
        .push_data (digit),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            msg       <= '0;
            frame_cnt <= '0;
            wait_cnt  <= '0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            led       <= 8'h00;
            overflow  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            overflow <= ovf_next;
            led[7]   <= ovf_next;

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        msg       <= fifo_dout;
                        idx       <= '0;
                        frame_cnt <= frame_cnt + 3'd1;
                        led[6:0]  <= {frame_cnt + 3'd1, fifo_dout};
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (tx_rdy) begin
                        tx_start <= 1'b1;
                        tx_data  <= frame_byte(idx, msg);
                        wait_cnt <= '0;
                        state    <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    // Fourth cycle without a busy indication counts as acknowledged.
                    if (!tx_rdy || wait_cnt == 2'd3)
                        state <= WAIT_HI;
                    else
                        wait_cnt <= wait_cnt + 2'd1;
                end
                WAIT_HI: begin
                    if (tx_rdy) begin
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
